// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: one result bit per clock, with the result
// and destination register presented for register-file write-back on completion.
module mul_div_unit #(
    parameter int WIDTH      = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      operandA,
    input  logic [WIDTH-1:0]      operandB,
    input  logic [REG_ADDR_W-1:0] destReg,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [REG_ADDR_W-1:0] resultReg,
    output logic                  regWrite
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

    stateT                  state;
    stateT                  stateNext;
    logic [1:0]             opLatched;
    logic [WIDTH-1:0]       operandBLatched;
    logic [REG_ADDR_W-1:0]  destLatched;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     accNext;
    logic [CNT_W-1:0]       count;
    logic [WIDTH:0]         mulSum;
    logic [WIDTH:0]         divShifted;
    logic [WIDTH-1:0]       divDiff;
    logic                   divGeq;
    logic                   lastIter;
    logic                   divByZero;
    logic                   accept;
    logic                   enterDone;
    logic [WIDTH-1:0]       finalValue;

    // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mulSum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operandBLatched} : '0);
        divShifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divGeq     = divShifted >= {1'b0, operandBLatched};
        divDiff    = divShifted[WIDTH-1:0] - operandBLatched;
        accNext    = acc;
        if (state == MUL) begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end else if (state == DIV) begin
            accNext = {(divGeq ? divDiff : divShifted[WIDTH-1:0]), acc[WIDTH-2:0], divGeq};
        end
    end

    assign lastIter  = (count == CNT_W'(WIDTH - 1));
    assign divByZero = (state == DIV) && (operandBLatched == '0);
    assign accept    = ((state == IDLE) || (state == DONE)) && start;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext = op[1] ? DIV : MUL;
                end else begin
                    stateNext = IDLE;
                end
            end
            MUL: begin
                if (lastIter) begin
                    stateNext = DONE;
                end
            end
            DIV: begin
                if (divByZero || lastIter) begin
                    stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign enterDone = ((state == MUL) || (state == DIV)) && (stateNext == DONE);

    // op[0] selects the upper half in both modes: MULHI/REMU high, MULLO/DIVU low
    always_comb begin
        finalValue = opLatched[0] ? accNext[2*WIDTH-1:WIDTH] : accNext[WIDTH-1:0];
        if (divByZero) begin
            finalValue = opLatched[0] ? acc[WIDTH-1:0] : '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opLatched       <= '0;
            operandBLatched <= '0;
            destLatched     <= '0;
            acc             <= '0;
            count           <= '0;
            result          <= '0;
            resultReg       <= '0;
        end else begin
            if (accept) begin
                opLatched       <= op;
                operandBLatched <= operandB;
                destLatched     <= destReg;
                acc             <= {{WIDTH{1'b0}}, operandA};
                count           <= '0;
            end else if ((state == MUL) || (state == DIV)) begin
                acc   <= accNext;
                count <= count + 1'b1;
            end
            if (enterDone) begin
                result    <= finalValue;
                resultReg <= destLatched;
            end
        end
    end

    assign busy     = (state == MUL) || (state == DIV);
    assign done     = (state == DONE);
    assign regWrite = done && (resultReg != '0);

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 64-bit unsigned multiply/divide execution unit.
- Sits directly downstream of the register file: takes readData1/readData2 as operands.
- Produces a result plus a write-back request (result, destination register, write enable) that drives the register file's writeData/writeReg/regWrite port.
- Multi-cycle: one bit per clock, with a start/busy/done handshake.

Parameters:
- WIDTH, 64, operand and result width in bits.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled on a rising edge.
- op  input  2  operation select: 00 MULLO (low 64 bits of product), 01 MULHI (high 64 bits of product), 10 DIVU (quotient), 11 REMU (remainder).
- operandA  input  WIDTH  multiplicand or dividend (from readData1).
- operandB  input  WIDTH  multiplier or divisor (from readData2).
- destReg  input  REG_ADDR_W  destination register index.
- busy  output  1  unit is computing.
- done  output  1  one-cycle pulse: result is valid.
- result  output  WIDTH  operation result.
- resultReg  output  REG_ADDR_W  latched destReg, for write-back.
- regWrite  output  1  write-back enable to the register file.

Behaviour:
- Reset is synchronous and active-high; single clock domain (clk).
- When rst=1 at a rising edge:
  - state=IDLE, busy=0, done=0, regWrite=0, result=0, resultReg=0, iteration counter=0.
  - Takes priority over every other input, including mid-operation. An aborted operation never produces done or regWrite.
- States: IDLE, MUL, DIV, DONE.
  - IDLE/DONE + start=1 at edge E0: latch op, operandA, operandB and destReg into internal registers, clear the counter, go to MUL (op=0x) or DIV (op=1x). Later changes on the inputs are ignored.
  - DONE + start=0: go to IDLE.
  - MUL/DIV: start is ignored. Exactly one iteration per edge, counter+1. After the 64th iteration (edge E64) go to DONE.
  - DIV with latched operandB==0: fast path, go to DONE at E1.
- Outputs by state:
  - busy=1 exactly while in MUL or DIV.
  - done=1 exactly while in DONE, so it is a single-cycle pulse. done is visible in the cycle after E64 (after E1 for divide-by-zero).
  - regWrite = done AND (resultReg != 0). Writes to x0 are suppressed; done still pulses.
  - result and resultReg update only on entry to DONE and then hold until the next DONE. result is undefined-free: it holds its prior value while busy.
- Multiply: shift-add over a 128-bit accumulator. MULLO returns product[63:0]; MULHI returns product[127:64]. The exact unsigned product is required, with no truncation before selection.
- Divide: restoring shift-subtract, one quotient bit per cycle, 64-bit remainder. Both must satisfy dividend = quotient*divisor + remainder with remainder < divisor.
- Divide-by-zero: DIVU returns all ones (0xFFFF_FFFF_FFFF_FFFF); REMU returns operandA.
- Back-to-back: a start while in DONE is accepted at that edge. The next done can then follow 65 cycles after the previous done.
- operandA/operandB=0 or all ones must produce exact results; there are no special cases beyond the divisor==0 fast path.

Test Plan:
- Basic MULLO: reset 2 cycles, then start with op=00, A=3, B=5, destReg=7 at E0 -> busy=1 for 64 cycles; after E64, done=1 for exactly 1 cycle with result=15, resultReg=7, regWrite=1; then idle with busy=0 and done=0.
- Multiply overflow: A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> MULHI gives result=1; MULLO gives result=0xFFFF_FFFF_FFFF_FFFE.
- Divide: A=100, B=7 -> DIVU gives 14; REMU gives 2. A=5, B=9 -> DIVU gives 0; REMU gives 5.
- Divide-by-zero: A=42, B=0, DIVU -> done in the cycle after E1 with result=0xFFFF_FFFF_FFFF_FFFF. Same with REMU -> result=42.
- Handshake and reset:
  - Pulse start with different operands at E10 of a running MULLO 3*5 -> ignored; the result is still 15.
  - Assert rst at E30 of a new operation -> busy=0 after that edge, no done or regWrite ever appears.
  - Then run DIVU 100/7 -> result 14.
- x0 write and back-to-back: MULLO 6*7 with destReg=0 -> done pulses with result=42 and regWrite stays 0. Assert start during that DONE cycle with MULLO 2*3, destReg=1 -> accepted; done appears 65 cycles later with result=6 and regWrite=1.
